// File: rtl/oc8051_ecall_ctrl_pkg.sv
// Shared types and SFR addresses for the oc8051 ECALL/ERET sequencer.
// The SFR addresses sit next to the existing ETR addresses in the SFR map.
package oc8051_ecall_ctrl_pkg;

    localparam logic [7:0] OC8051_SFR_ERA_LO = 8'hA9;
    localparam logic [7:0] OC8051_SFR_ERA_HI = 8'hAA;
    localparam logic [7:0] OC8051_SFR_ESTAT  = 8'hAB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SAVE = 2'd1,
        ST_JUMP = 2'd2,
        ST_RET  = 2'd3
    } ecall_state_e;

endpackage

// File: rtl/oc8051_ecall_ctrl.sv
// ECALL/ERET sequencer: saves the return address in ERA, redirects the PC to ETR,
// tracks privileged mode, stalls the pipeline during transitions and reports faults in ESTAT.
module oc8051_ecall_ctrl
    import oc8051_ecall_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         ecall_req,
    input  logic         eret_req,
    input  logic [15:0]  pc_ret,
    input  logic [15:0]  etr,
    input  logic         wr,
    input  logic         wr_bit,
    input  logic [7:0]   wr_addr,
    input  logic [7:0]   data_in,
    input  logic [7:0]   rd_addr,
    output logic         pc_wr,
    output logic [15:0]  pc_out,
    output logic         stall,
    output logic         priv,
    output logic         etr_wr_en,
    output logic [7:0]   data_out,
    output logic         sfr_hit,
    output ecall_state_e dbg_state
);

    localparam logic [1:0] CAUSE_BOTH      = 2'b00;
    localparam logic [1:0] CAUSE_ECALL_PRV = 2'b01;
    localparam logic [1:0] CAUSE_ERET_USR  = 2'b10;
    localparam logic [1:0] CAUSE_ETR_ZERO  = 2'b11;

    ecall_state_e state_q, state_d;
    logic [15:0]  era_q, era_d;
    logic         priv_q, priv_d;
    logic         fault_q, fault_d;
    logic [1:0]   cause_q, cause_d;

    logic         estat_clr;
    logic         fault_set;
    logic [1:0]   fault_cause;
    logic [6:0]   unused_data_in;

    assign unused_data_in = data_in[7:1];

    // Only byte writes clear ESTAT; bit-addressed writes are not decoded here.
    assign estat_clr = wr & ~wr_bit & (wr_addr == OC8051_SFR_ESTAT) & data_in[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            era_q   <= 16'h0000;
            priv_q  <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            era_q   <= era_d;
            priv_q  <= priv_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        era_d       = era_q;
        priv_d      = priv_q;
        stall       = 1'b0;
        pc_wr       = 1'b0;
        pc_out      = 16'h0000;
        fault_set   = 1'b0;
        fault_cause = CAUSE_BOTH;

        case (state_q)
            ST_IDLE: begin
                if (ecall_req && eret_req) begin
                    fault_set   = 1'b1;
                    fault_cause = CAUSE_BOTH;
                end else if (ecall_req) begin
                    if (priv_q) begin
                        fault_set   = 1'b1;
                        fault_cause = CAUSE_ECALL_PRV;
                    end else if (etr == 16'h0000) begin
                        fault_set   = 1'b1;
                        fault_cause = CAUSE_ETR_ZERO;
                    end else begin
                        era_d   = pc_ret;
                        state_d = ST_SAVE;
                    end
                end else if (eret_req) begin
                    if (!priv_q) begin
                        fault_set   = 1'b1;
                        fault_cause = CAUSE_ERET_USR;
                    end else begin
                        state_d = ST_RET;
                    end
                end
            end
            ST_SAVE: begin
                stall   = 1'b1;
                state_d = ST_JUMP;
            end
            // ETR is taken live here so a write landing during SAVE is honoured.
            ST_JUMP: begin
                stall   = 1'b1;
                pc_wr   = 1'b1;
                pc_out  = etr;
                priv_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_RET: begin
                stall   = 1'b1;
                pc_wr   = 1'b1;
                pc_out  = era_q;
                priv_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A fault in the same cycle as a clear takes precedence.
    always_comb begin
        fault_d = fault_q;
        cause_d = cause_q;
        if (estat_clr) begin
            fault_d = 1'b0;
            cause_d = 2'b00;
        end
        if (fault_set) begin
            fault_d = 1'b1;
            cause_d = fault_cause;
        end
    end

    always_comb begin
        data_out = 8'h00;
        sfr_hit  = 1'b0;
        case (rd_addr)
            OC8051_SFR_ERA_LO: begin
                data_out = era_q[7:0];
                sfr_hit  = 1'b1;
            end
            OC8051_SFR_ERA_HI: begin
                data_out = era_q[15:8];
                sfr_hit  = 1'b1;
            end
            OC8051_SFR_ESTAT: begin
                data_out = {priv_q, 4'b0000, cause_q, fault_q};
                sfr_hit  = 1'b1;
            end
            default: begin
                data_out = 8'h00;
                sfr_hit  = 1'b0;
            end
        endcase
    end

    assign priv      = priv_q;
    assign etr_wr_en = priv_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_oc8051_ecall_ctrl.sv
// Directed bench for oc8051_ecall_ctrl: expected PC loads go into a queue that a
// monitor drains on every pc_wr; register and status values are checked inline.
module tb_oc8051_ecall_ctrl;
    import oc8051_ecall_ctrl_pkg::*;

    logic         clk;
    logic         rst;
    logic         ecall_req;
    logic         eret_req;
    logic [15:0]  pc_ret;
    logic [15:0]  etr;
    logic         wr;
    logic         wr_bit;
    logic [7:0]   wr_addr;
    logic [7:0]   data_in;
    logic [7:0]   rd_addr;
    logic         pc_wr;
    logic [15:0]  pc_out;
    logic         stall;
    logic         priv;
    logic         etr_wr_en;
    logic [7:0]   data_out;
    logic         sfr_hit;
    ecall_state_e dbg_state;

    logic [15:0]  exp_q[$];
    int           total;
    int           bad;

    oc8051_ecall_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .ecall_req (ecall_req),
        .eret_req  (eret_req),
        .pc_ret    (pc_ret),
        .etr       (etr),
        .wr        (wr),
        .wr_bit    (wr_bit),
        .wr_addr   (wr_addr),
        .data_in   (data_in),
        .rd_addr   (rd_addr),
        .pc_wr     (pc_wr),
        .pc_out    (pc_out),
        .stall     (stall),
        .priv      (priv),
        .etr_wr_en (etr_wr_en),
        .data_out  (data_out),
        .sfr_hit   (sfr_hit),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: every PC load must match the oldest expected target
    always @(negedge clk) begin
        if (pc_wr === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pc_wr_unexpected: got pc_out 0x%0h expected no load at %0t", pc_out, $time);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (pc_out !== e) begin
                    bad++;
                    $display("FAIL pc_out: got 0x%0h expected 0x%0h at %0t", pc_out, e, $time);
                end
            end
        end else if (pc_out !== 16'h0000) begin
            total++;
            bad++;
            $display("FAIL pc_out_idle: got 0x%0h expected 0x0 at %0t", pc_out, $time);
        end
    end

    // driver tasks; all called and returning at posedge+1
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ecall(input logic [15:0] pc, input logic [15:0] target);
        pc_ret    = pc;
        etr       = target;
        ecall_req = 1'b1;
        tick();
        ecall_req = 1'b0;
    endtask

    task automatic do_eret();
        eret_req = 1'b1;
        tick();
        eret_req = 1'b0;
    endtask

    task automatic sfr_write(input logic [7:0] addr, input logic [7:0] val);
        wr      = 1'b1;
        wr_bit  = 1'b0;
        wr_addr = addr;
        data_in = val;
        tick();
        wr      = 1'b0;
        data_in = 8'h00;
    endtask

    task automatic read_chk(input string name, input logic [7:0] addr, input logic [7:0] exp);
        rd_addr = addr;
        #1;
        chk(name, {8'h00, data_out}, {8'h00, exp});
        chk({name, "_hit"}, {15'h0, sfr_hit}, 16'h0001);
        rd_addr = 8'h00;
    endtask

    // full ECALL into privileged mode with expected jump target
    task automatic enter_priv(input logic [15:0] pc, input logic [15:0] target);
        exp_q.push_back(target);
        do_ecall(pc, target);
        tick();
        tick();
        chk("enter_priv", {15'h0, priv}, 16'h0001);
    endtask

    task automatic leave_priv(input logic [15:0] pc);
        exp_q.push_back(pc);
        do_eret();
        tick();
        chk("leave_priv", {15'h0, priv}, 16'h0000);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        ecall_req = 1'b0;
        eret_req  = 1'b0;
        pc_ret    = 16'h0000;
        etr       = 16'h0000;
        wr        = 1'b0;
        wr_bit    = 1'b0;
        wr_addr   = 8'h00;
        data_in   = 8'h00;
        rd_addr   = 8'h00;
        repeat (3) tick();

        // reset state
        @(negedge clk);
        chk("rst_pc_wr", {15'h0, pc_wr}, 16'h0000);
        chk("rst_stall", {15'h0, stall}, 16'h0000);
        chk("rst_priv", {15'h0, priv}, 16'h0000);
        chk("rst_data_out", {8'h0, data_out}, 16'h0000);
        chk("rst_sfr_hit", {15'h0, sfr_hit}, 16'h0000);
        chk("rst_state", {14'h0, dbg_state}, {14'h0, ST_IDLE});
        rst = 1'b0;
        tick();
        read_chk("rst_era_lo", OC8051_SFR_ERA_LO, 8'h00);
        read_chk("rst_estat", OC8051_SFR_ESTAT, 8'h00);

        // ECALL etr=0x1234 pc_ret=0x0456, sampled at N
        exp_q.push_back(16'h1234);
        do_ecall(16'h0456, 16'h1234);
        @(negedge clk);
        chk("n1_stall", {15'h0, stall}, 16'h0001);
        chk("n1_pc_wr", {15'h0, pc_wr}, 16'h0000);
        chk("n1_priv", {15'h0, priv}, 16'h0000);
        tick();
        @(negedge clk);
        chk("n2_stall", {15'h0, stall}, 16'h0001);
        chk("n2_pc_wr", {15'h0, pc_wr}, 16'h0001);
        chk("n2_priv", {15'h0, priv}, 16'h0000);
        tick();
        @(negedge clk);
        chk("n3_priv", {15'h0, priv}, 16'h0001);
        chk("n3_etr_wr_en", {15'h0, etr_wr_en}, 16'h0001);
        chk("n3_stall", {15'h0, stall}, 16'h0000);
        tick();
        read_chk("era_lo", OC8051_SFR_ERA_LO, 8'h56);
        read_chk("era_hi", OC8051_SFR_ERA_HI, 8'h04);
        sfr_write(OC8051_SFR_ERA_LO, 8'hFF);
        read_chk("era_lo_ro", OC8051_SFR_ERA_LO, 8'h56);

        // ERET at M
        exp_q.push_back(16'h0456);
        do_eret();
        @(negedge clk);
        chk("m1_stall", {15'h0, stall}, 16'h0001);
        chk("m1_pc_wr", {15'h0, pc_wr}, 16'h0001);
        chk("m1_priv", {15'h0, priv}, 16'h0001);
        tick();
        @(negedge clk);
        chk("m2_priv", {15'h0, priv}, 16'h0000);
        chk("m2_etr_wr_en", {15'h0, etr_wr_en}, 16'h0000);
        tick();

        // ERET while not privileged
        do_eret();
        repeat (2) tick();
        read_chk("eret_usr_estat", OC8051_SFR_ESTAT, 8'h05);
        sfr_write(OC8051_SFR_ESTAT, 8'h01);
        read_chk("estat_cleared", OC8051_SFR_ESTAT, 8'h00);

        // ECALL with etr == 0
        do_ecall(16'h0111, 16'h0000);
        repeat (2) tick();
        chk("etr0_priv", {15'h0, priv}, 16'h0000);
        read_chk("etr0_estat", OC8051_SFR_ESTAT, 8'h07);
        sfr_write(OC8051_SFR_ESTAT, 8'h01);

        // ECALL while privileged
        enter_priv(16'h0100, 16'h2000);
        do_ecall(16'h0222, 16'h3000);
        repeat (2) tick();
        read_chk("ecall_prv_estat", OC8051_SFR_ESTAT, 8'h83);
        read_chk("ecall_prv_era", OC8051_SFR_ERA_LO, 8'h00);
        sfr_write(OC8051_SFR_ESTAT, 8'h01);
        read_chk("prv_cleared", OC8051_SFR_ESTAT, 8'h80);
        leave_priv(16'h0100);

        // simultaneous requests
        pc_ret    = 16'h0333;
        etr       = 16'h4444;
        ecall_req = 1'b1;
        eret_req  = 1'b1;
        tick();
        ecall_req = 1'b0;
        eret_req  = 1'b0;
        @(negedge clk);
        chk("both_state", {14'h0, dbg_state}, {14'h0, ST_IDLE});
        chk("both_stall", {15'h0, stall}, 16'h0000);
        tick();
        read_chk("both_estat", OC8051_SFR_ESTAT, 8'h01);
        sfr_write(OC8051_SFR_ESTAT, 8'h01);

        // second ECALL during SAVE is ignored
        exp_q.push_back(16'h4000);
        do_ecall(16'h0200, 16'h4000);
        pc_ret    = 16'h0999;
        ecall_req = 1'b1;
        tick();
        ecall_req = 1'b0;
        repeat (3) tick();
        chk("save_ign_priv", {15'h0, priv}, 16'h0001);
        read_chk("save_ign_estat", OC8051_SFR_ESTAT, 8'h80);
        read_chk("save_ign_era", OC8051_SFR_ERA_HI, 8'h02);
        leave_priv(16'h0200);

        // fault wins over same-cycle clear
        wr        = 1'b1;
        wr_addr   = OC8051_SFR_ESTAT;
        data_in   = 8'h01;
        eret_req  = 1'b1;
        tick();
        wr        = 1'b0;
        eret_req  = 1'b0;
        data_in   = 8'h00;
        read_chk("fault_over_clr", OC8051_SFR_ESTAT, 8'h05);
        sfr_write(OC8051_SFR_ESTAT, 8'h01);

        // reset during SAVE abandons the jump
        do_ecall(16'h0300, 16'h5000);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_save_state", {14'h0, dbg_state}, {14'h0, ST_IDLE});
        chk("rst_save_pc_wr", {15'h0, pc_wr}, 16'h0000);
        chk("rst_save_priv", {15'h0, priv}, 16'h0000);
        tick();
        rst = 1'b0;
        read_chk("rst_save_era_lo", OC8051_SFR_ERA_LO, 8'h00);
        read_chk("rst_save_era_hi", OC8051_SFR_ERA_HI, 8'h00);
        enter_priv(16'h0345, 16'h6000);
        read_chk("post_rst_era", OC8051_SFR_ERA_LO, 8'h45);
        leave_priv(16'h0345);

        repeat (4) tick();
        chk("exp_q_drained", 16'(exp_q.size()), 16'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/oc8051_ecall_ctrl.md
# oc8051_ecall_ctrl

Sequencer for the ECALL/ERET secure-call mechanism of the oc8051 secure-boot core. It takes decoded ECALL/ERET requests from the instruction decoder and saves the return address into an ECALL Return Address register (ERA). It redirects the PC to the current ECALL target (ETR) value, tracks the privileged-mode bit and stalls the pipeline during the transition. It sits beside the ETR register and the PC logic, exposes ERA and a status register on the SFR bus, and gates ETR writes to privileged mode.

## Interface
- No parameters. SFR addresses come from the shared defines.
- clk  in  1  core clock.
- rst  in  1  reset; synchronous and active-high (polarity and synchronicity fixed).
- ecall_req  in  1  decoder: ECALL instruction in execute, one-cycle pulse.
- eret_req  in  1  decoder: ERET instruction in execute, one-cycle pulse.
- pc_ret  in  16  address of the instruction following ECALL, valid with ecall_req.
- etr  in  16  current ECALL target from the ETR register, including same-cycle write bypass.
- wr, wr_bit  in  1  SFR write strobe; bit-addressed write flag.
- wr_addr, data_in  in  8  SFR write address and data.
- rd_addr  in  8  SFR read address.
- pc_wr  out  1  load PC with pc_out this cycle.
- pc_out  out  16  PC load value.
- stall  out  1  hold fetch/decode.
- priv  out  1  privileged (enclave) mode.
- etr_wr_en  out  1  ETR writes permitted; equals priv.
- data_out  out  8  SFR read data.
- sfr_hit  out  1  rd_addr decodes to ERA_LO, ERA_HI or ESTAT.

## Operation
- FSM states: IDLE, SAVE, JUMP, RET.
- IDLE, valid ECALL (ecall_req & !eret_req & !priv & etr != 0):
  - era <= pc_ret.
  - Go to SAVE.
- SAVE:
  - stall = 1.
  - Go to JUMP.
- JUMP:
  - stall = 1, pc_wr = 1, pc_out = etr as sampled this cycle.
  - priv <= 1.
  - Go to IDLE.
- IDLE, valid ERET (eret_req & !ecall_req & priv):
  - Go to RET.
- RET:
  - stall = 1, pc_wr = 1, pc_out = era.
  - priv <= 0.
  - Go to IDLE.
- Faults. Each sets sticky estat.fault (bit0), records a cause in estat[2:1], and causes no PC change or state change:
  - ECALL while priv: cause 01.
  - ERET while !priv: cause 10.
  - ECALL with etr == 0: cause 11.
  - ecall_req & eret_req together: cause 00 with fault set.
- estat bit7 reads priv. Bits 6:3 read 0.
- Clearing: a byte write to ESTAT with data_in[0] = 1 clears fault and cause. A fault arising in the same cycle wins over the clear.
- ERA_LO and ERA_HI are read-only. Writes to them are ignored.
- Requests arriving in SAVE, JUMP or RET are ignored. No fault is raised, because the decoder is stalled.
- pc_out = 0 whenever pc_wr = 0.

## Timing
- Reset values: state IDLE, era 0x0000, priv 0, estat 0x00. pc_wr, stall, pc_out, data_out and sfr_hit are 0.
- ECALL sampled in IDLE at cycle N:
  - stall high in N+1 and N+2.
  - pc_wr high in N+2.
  - priv high from N+3.
- ERET sampled at N:
  - stall and pc_wr high in N+1.
  - priv low from N+2.
- SFR read is combinational on rd_addr (same cycle). Read data reflects register values before any same-cycle update.
- Reset asserted in any state: next cycle is IDLE with all registers at reset values. Any in-flight jump is abandoned.

## Structure
- `oc8051_defines.v` gains `OC8051_SFR_ERA_LO`, `OC8051_SFR_ERA_HI` and `OC8051_SFR_ESTAT`, alongside the existing ETR addresses.
- State encodings and fault-cause codes are localparams in the module.
- Single module, no sub-modules. The SFR read mux is inline.

## Test plan
- ECALL, etr = 0x1234, pc_ret = 0x0456 at cycle N:
  - pc_wr in N+2 with pc_out = 0x1234.
  - priv = 1 from N+3.
  - ERA reads 0x56 / 0x04.
- Then ERET at cycle M:
  - pc_wr in M+1 with pc_out = 0x0456.
  - priv = 0 from M+2.
  - etr_wr_en follows priv.
- ERET while !priv:
  - No pc_wr.
  - ESTAT reads 0x05.
  - Write 0x01 to ESTAT, then reads 0x00.
- ECALL with etr = 0x0000: no pc_wr, priv stays 0, ESTAT = 0x07. Repeat with ECALL while priv = 1: ESTAT = 0x83.
- Simultaneous ecall_req and eret_req: no state change, ESTAT bit0 = 1. Separately, a second ecall_req during SAVE is ignored and only one jump occurs.
- rst asserted during SAVE:
  - Next cycle IDLE, pc_wr = 0, priv = 0, era = 0.
  - A following ECALL completes normally.
